// File: rtl/tape_pkg.sv
// Shared definitions for the tape controller: head-move encodings, the step
// FSM state type and the default home-position expression.
package tape_pkg;

  // Head move encodings carried on cmd_move; MOVE_HOLD behaves as a stay.
  typedef enum logic [1:0] {
    MOVE_STAY  = 2'b00,
    MOVE_LEFT  = 2'b01,
    MOVE_RIGHT = 2'b10,
    MOVE_HOLD  = 2'b11
  } move_e;

  // One command walks IDLE -> EXEC -> READ -> CAPT -> RESP -> IDLE.
  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    READ,
    CAPT,
    RESP
  } state_e;

  // Default head position after reset: the middle of the tape.
  function automatic int unsigned home_addr_default(input int unsigned addr_space);
    return 32'd1 << (addr_space - 1);
  endfunction

endpackage

// File: rtl/tape_controller.sv
// Turing-style tape controller: per command, optionally writes a symbol at the
// head, moves the head, reads back the symbol under the new head position and
// hands it out on a valid/ready response channel. The tape memory lives outside
// and is reached through the mem_* ports (registered read, read-before-write).
// Optional feature: define TAPE_BOUNDS_EN to stop the head at the tape edges
// and flag rsp_err; otherwise the head wraps and rsp_err stays 0.
module tape_controller
  import tape_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_SPACE = 14,
  parameter int unsigned HOME_ADDR  = home_addr_default(ADDR_SPACE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [DATA_WIDTH-1:0] cmd_sym,
  input  logic [1:0]            cmd_move,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_sym,
  output logic                  rsp_err,
  output logic [ADDR_SPACE-1:0] head_pos,
  output logic [31:0]           step_cnt,
  output logic [ADDR_SPACE-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_out
);

  localparam logic [ADDR_SPACE-1:0] HOME = ADDR_SPACE'(HOME_ADDR);
  localparam logic [ADDR_SPACE-1:0] ONE  = {{(ADDR_SPACE-1){1'b0}}, 1'b1};

  state_e                  state;
  move_e                   lat_move;
  logic [ADDR_SPACE-1:0]   head_next;

`ifdef TAPE_BOUNDS_EN
  logic                    edge_hit;
  logic                    step_err;

  // Next head position; a move past either tape edge is refused and flagged.
  always_comb begin
    head_next = head_pos;
    edge_hit  = 1'b0;
    case (lat_move)
      MOVE_LEFT: begin
        if (head_pos == '0) edge_hit  = 1'b1;
        else                head_next = head_pos - ONE;
      end
      MOVE_RIGHT: begin
        if (head_pos == '1) edge_hit  = 1'b1;
        else                head_next = head_pos + ONE;
      end
      default: head_next = head_pos;
    endcase
  end
`else
  // Next head position; the tape is circular so moves wrap at the edges.
  always_comb begin
    head_next = head_pos;
    case (lat_move)
      MOVE_LEFT:  head_next = head_pos - ONE;
      MOVE_RIGHT: head_next = head_pos + ONE;
      default:    head_next = head_pos;
    endcase
  end
`endif

  // Step FSM with all outputs registered. The write flag and symbol are held
  // in mem_we/mem_data from acceptance through EXEC, so no separate copies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      lat_move  <= MOVE_STAY;
      head_pos  <= HOME;
      step_cnt  <= '0;
      rsp_sym   <= '0;
      rsp_err   <= 1'b0;
      rsp_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
`ifdef TAPE_BOUNDS_EN
      step_err  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            mem_addr  <= head_pos;
            mem_we    <= cmd_write;
            mem_data  <= cmd_sym;
            lat_move  <= move_e'(cmd_move);
            cmd_ready <= 1'b0;
            state     <= EXEC;
          end
        end
        EXEC: begin
          head_pos <= head_next;
          mem_addr <= head_next;
          mem_we   <= 1'b0;
`ifdef TAPE_BOUNDS_EN
          step_err <= edge_hit;
`endif
          state    <= READ;
        end
        READ: begin
          state <= CAPT;
        end
        CAPT: begin
          rsp_sym   <= mem_out;
`ifdef TAPE_BOUNDS_EN
          rsp_err   <= step_err;
`else
          rsp_err   <= 1'b0;
`endif
          if (step_cnt != '1) step_cnt <= step_cnt + 32'd1;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          mem_we    <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
